// File: rtl/cfg_seq_pkg.sv
// Shared types and header field positions for the column frame strobe sequencer.
package cfg_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      SETUP,
      STROBE,
      CHECK
   } seqState_t;

   localparam int HDR_FLAG_BIT = 31;
   localparam int COL_HI       = 23;
   localparam int COL_LO       = 16;
   localparam int START_HI     = 15;
   localparam int START_LO     = 8;
   localparam int CNT_HI       = 7;
   localparam int CNT_LO       = 0;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered index-to-one-hot decoder; the output is all zero unless enable is high
// and the index falls inside the strobe vector.
module frame_strobe_decoder #(
   parameter int Width = 20
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enable,
   input  logic [7:0]       index,
   output logic [Width-1:0] strobe
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         strobe <= '0;
      end else begin
         for (int i = 0; i < Width; i++) begin
            strobe[i] <= enable && (32'(index) == i);
         end
      end
   end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Column config front end: header/data word stream in, FrameData plus one-hot FrameStrobe out.
// Optional trailer checksum word is enabled with `define CONFIG_WORD_CHECKSUM_EN.
module frame_strobe_sequencer
   import cfg_seq_pkg::*;
#(
   parameter int         MaxFramesPerCol = 20,
   parameter int         FrameBitsPerRow = 32,
   parameter logic [7:0] ColumnId        = 8'd0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [31:0]                WordData,
   input  logic                       WordValid,
   output logic                       WordReady,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       Busy,
   output logic                       Error,
   input  logic                       ErrorClear
);

   seqState_t  state;
   logic [7:0] frameIdx;
   logic [7:0] remaining;
   logic       colMatch;
   logic       wordAccept;
   logic       idxInRange;
   logic       strobeEnable;
   logic       errorEvent;
`ifdef CONFIG_WORD_CHECKSUM_EN
   logic [31:0] checkSum;
`endif

   assign wordAccept   = WordValid && WordReady;
   assign idxInRange   = 32'(frameIdx) < MaxFramesPerCol;
   // Strobe register loads during SETUP so the pulse occupies exactly the STROBE cycle.
   assign strobeEnable = (state == SETUP) && colMatch && idxInRange;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      errorEvent = 1'b0;
      if (state == IDLE && wordAccept && !WordData[HDR_FLAG_BIT]) errorEvent = 1'b1;
      if (state == STROBE && colMatch && !idxInRange)             errorEvent = 1'b1;
`ifdef CONFIG_WORD_CHECKSUM_EN
      if (state == CHECK && wordAccept && WordData != checkSum)   errorEvent = 1'b1;
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         frameIdx  <= '0;
         remaining <= '0;
         colMatch  <= 1'b0;
         FrameData <= '0;
         WordReady <= 1'b0;
         Busy      <= 1'b0;
         Error     <= 1'b0;
`ifdef CONFIG_WORD_CHECKSUM_EN
         checkSum  <= '0;
`endif
      end else begin
         // A new error event wins over a simultaneous clear.
         Error <= errorEvent || (Error && !ErrorClear);
         case (state)
            IDLE: begin
               WordReady <= 1'b1;
               Busy      <= 1'b0;
               if (wordAccept && WordData[HDR_FLAG_BIT]) begin
                  state     <= DATA;
                  Busy      <= 1'b1;
                  frameIdx  <= WordData[START_HI:START_LO];
                  remaining <= WordData[CNT_HI:CNT_LO];
                  colMatch  <= (WordData[COL_HI:COL_LO] == ColumnId);
`ifdef CONFIG_WORD_CHECKSUM_EN
                  checkSum  <= '0;
`endif
               end
            end
            DATA: begin
               if (wordAccept) begin
                  if (colMatch && idxInRange) FrameData <= WordData;
`ifdef CONFIG_WORD_CHECKSUM_EN
                  checkSum  <= checkSum ^ WordData;
`endif
                  state     <= SETUP;
                  WordReady <= 1'b0;
               end
            end
            SETUP: begin
               state <= STROBE;
            end
            STROBE: begin
               frameIdx  <= frameIdx + 8'd1;
               WordReady <= 1'b1;
               if (remaining == 8'd0) begin
`ifdef CONFIG_WORD_CHECKSUM_EN
                  state <= CHECK;
`else
                  state <= IDLE;
                  Busy  <= 1'b0;
`endif
               end else begin
                  remaining <= remaining - 8'd1;
                  state     <= DATA;
               end
            end
            CHECK: begin
`ifdef CONFIG_WORD_CHECKSUM_EN
               if (wordAccept) begin
                  state <= IDLE;
                  Busy  <= 1'b0;
               end
`else
               state <= IDLE;
               Busy  <= 1'b0;
`endif
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

   frame_strobe_decoder #(
      .Width(MaxFramesPerCol)
   ) strobeDecoder (
      .CLK   (CLK),
      .RST   (RST),
      .enable(strobeEnable),
      .index (frameIdx),
      .strobe(FrameStrobe)
   );

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed self-checking bench for frame_strobe_sequencer; honours CONFIG_WORD_CHECKSUM_EN.
module tb_frame_strobe_sequencer;

   localparam int MaxFrames = 20;

`ifdef CONFIG_WORD_CHECKSUM_EN
   localparam logic BusyAfterLastStrobe = 1'b1;
`else
   localparam logic BusyAfterLastStrobe = 1'b0;
`endif

   logic                 CLK = 1'b0;
   logic                 RST = 1'b1;
   logic [31:0]          WordData = '0;
   logic                 WordValid = 1'b0;
   logic                 WordReady;
   logic [31:0]          FrameData;
   logic [MaxFrames-1:0] FrameStrobe;
   logic                 Busy;
   logic                 Error;
   logic                 ErrorClear = 1'b0;

   int assertCount = 0;
   int failCount   = 0;

   frame_strobe_sequencer #(
      .MaxFramesPerCol(MaxFrames),
      .FrameBitsPerRow(32),
      .ColumnId       (8'd0)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .WordData   (WordData),
      .WordValid  (WordValid),
      .WordReady  (WordReady),
      .FrameData  (FrameData),
      .FrameStrobe(FrameStrobe),
      .Busy       (Busy),
      .Error      (Error),
      .ErrorClear (ErrorClear)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present a word and hold it until accepted; returns 1ns after the accepting edge.
   task automatic sendWord(input logic [31:0] d);
      bit accepted = 1'b0;
      WordData  = d;
      WordValid = 1'b1;
      for (int i = 0; i < 16 && !accepted; i++) begin
         @(negedge CLK);
         if (WordReady) begin
            @(posedge CLK);
            #1;
            accepted = 1'b1;
         end
      end
      if (!accepted) check("accept_timeout", 32'(WordReady), 32'd1);
      WordValid = 1'b0;
   endtask

   // Send one data word and check the strobe seen in the following cycle.
   task automatic dataWord(input string tag, input logic [31:0] d, input logic [31:0] expStrobe);
      sendWord(d);
      @(posedge CLK);
      #1;
      check(tag, 32'(FrameStrobe), expStrobe);
   endtask

   task automatic finishPacket(input logic [31:0] trailer);
`ifdef CONFIG_WORD_CHECKSUM_EN
      sendWord(trailer);
`else
      if (trailer == 32'hFFFF_FFFF) #0;
`endif
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_strobe", 32'(FrameStrobe), 32'd0);
      check("rst_data", FrameData, 32'd0);
      check("rst_ready", 32'(WordReady), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_error", 32'(Error), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      check("ready_after_rst", 32'(WordReady), 32'd1);

      // Single word packet, column 0, frame 3
      sendWord(32'h8000_0300);
      check("hdr_busy", 32'(Busy), 32'd1);
      sendWord(32'hDEAD_BEEF);
      check("t1_data_before_strobe", FrameData, 32'hDEAD_BEEF);
      check("t1_no_strobe_yet", 32'(FrameStrobe), 32'd0);
      check("t1_ready_low_setup", 32'(WordReady), 32'd0);
      @(posedge CLK);
      #1;
      check("t1_strobe", 32'(FrameStrobe), 32'h0000_0008);
      check("t1_data_held", FrameData, 32'hDEAD_BEEF);
      @(posedge CLK);
      #1;
      check("t1_strobe_fall", 32'(FrameStrobe), 32'd0);
      check("t1_busy_after", 32'(Busy), 32'(BusyAfterLastStrobe));
      finishPacket(32'hDEAD_BEEF);
      check("t1_busy_idle", 32'(Busy), 32'd0);
      check("t1_error", 32'(Error), 32'd0);

      // Start 18, three words: third index out of range
      sendWord(32'h8000_1202);
      dataWord("t2_strobe18", 32'h1111_1111, 32'h0004_0000);
      dataWord("t2_strobe19", 32'h2222_2222, 32'h0008_0000);
      check("t2_error_before_oor", 32'(Error), 32'd0);
      dataWord("t2_strobe_oor", 32'h3333_3333, 32'd0);
      check("t2_data_not_written", FrameData, 32'h2222_2222);
      @(posedge CLK);
      #1;
      check("t2_error_set", 32'(Error), 32'd1);
      finishPacket(32'h1111_1111 ^ 32'h2222_2222 ^ 32'h3333_3333);
      ErrorClear = 1'b1;
      @(posedge CLK);
      #1;
      ErrorClear = 1'b0;
      check("t2_error_cleared", 32'(Error), 32'd0);

      // Column mismatch: consumed silently
      sendWord(32'h8005_0001);
      dataWord("t3_no_strobe_a", 32'hAAAA_5555, 32'd0);
      dataWord("t3_no_strobe_b", 32'h5555_AAAA, 32'd0);
      check("t3_data_untouched", FrameData, 32'h2222_2222);
      @(posedge CLK);
      #1;
      finishPacket(32'hAAAA_5555 ^ 32'h5555_AAAA);
      check("t3_error", 32'(Error), 32'd0);
      check("t3_busy", 32'(Busy), 32'd0);

      // Malformed header
      sendWord(32'h0000_0000);
      check("t4_error", 32'(Error), 32'd1);
      check("t4_busy", 32'(Busy), 32'd0);
      check("t4_ready_idle", 32'(WordReady), 32'd1);
      ErrorClear = 1'b1;
      @(posedge CLK);
      #1;
      ErrorClear = 1'b0;
      check("t4_error_cleared", 32'(Error), 32'd0);

      // Reset during STROBE of a 4-word packet
      sendWord(32'h8000_0003);
      dataWord("t5_strobe0", 32'hCAFE_F00D, 32'h0000_0001);
      RST = 1'b1;
      #1;
      check("t5_rst_strobe", 32'(FrameStrobe), 32'd0);
      check("t5_rst_busy", 32'(Busy), 32'd0);
      check("t5_rst_data", FrameData, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      check("t5_ready_again", 32'(WordReady), 32'd1);
      sendWord(32'h8000_0500);
      sendWord(32'h1234_5678);
      check("t5_data", FrameData, 32'h1234_5678);
      @(posedge CLK);
      #1;
      check("t5_strobe5", 32'(FrameStrobe), 32'h0000_0020);
      @(posedge CLK);
      #1;
      finishPacket(32'h1234_5678);
      check("t5_error", 32'(Error), 32'd0);
      check("t5_busy", 32'(Busy), 32'd0);

`ifdef CONFIG_WORD_CHECKSUM_EN
      // Trailer checksum, good then bad
      sendWord(32'h8000_0001);
      dataWord("t6_strobe0", 32'h0F0F_0F0F, 32'h0000_0001);
      dataWord("t6_strobe1", 32'hF0F0_F0F0, 32'h0000_0002);
      sendWord(32'hFFFF_FFFF);
      check("t6_good_sum", 32'(Error), 32'd0);
      check("t6_idle", 32'(Busy), 32'd0);
      sendWord(32'h8000_0001);
      dataWord("t6b_strobe0", 32'h0F0F_0F0F, 32'h0000_0001);
      dataWord("t6b_strobe1", 32'hF0F0_F0F0, 32'h0000_0002);
      sendWord(32'hFFFF_FFFE);
      check("t6_bad_sum", 32'(Error), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
